// File: rtl/sha256_host_ctrl.sv
// Host-side controller for the SHA-256 co-processor: loads message words into shared
// memory, kicks the hasher with start/done, then streams the 8 digest words back out.
module sha256_host_ctrl #(
   parameter int unsigned NUM_OF_WORDS = 20,
   parameter logic [15:0] MESSAGE_ADDR = 16'd0,
   parameter logic [15:0] OUTPUT_ADDR  = 16'd1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        start,
   output logic [15:0] message_addr,
   output logic [15:0] output_addr,
   input  logic        done,
   output logic        mem_sel,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam int unsigned   IW     = $clog2(NUM_OF_WORDS + 1);
   localparam logic [IW-1:0] LAST_I = IW'(NUM_OF_WORDS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_WRLAST, S_START, S_WAIT, S_RADDR, S_RWAIT, S_RCAP, S_OUT
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [2:0]    j_q, j_d;
   logic          mem_we_q, mem_we_d;
   logic          mem_sel_q, mem_sel_d;
   logic [15:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_write_data_q, mem_write_data_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic          start_q, start_d;

   always_comb begin
      state_d          = state_q;
      i_d              = i_q;
      j_d              = j_q;
      mem_we_d         = 1'b0;
      mem_addr_d       = mem_addr_q;
      mem_write_data_d = mem_write_data_q;
      out_data_d       = out_data_q;
      out_valid_d      = out_valid_q;
      out_last_d       = out_last_q;
      start_d          = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_LOAD;
         S_LOAD: begin
            // in_ready is high throughout LOAD, so in_valid alone marks an accept
            if (in_valid) begin
               mem_we_d         = 1'b1;
               mem_addr_d       = MESSAGE_ADDR + 16'(i_q);
               mem_write_data_d = in_data;
               if (i_q == LAST_I) begin
                  i_d     = '0;
                  state_d = S_WRLAST;
               end else begin
                  i_d = i_q + IW'(1);
               end
            end
         end
         S_WRLAST: begin
            start_d = 1'b1;
            state_d = S_START;
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (done) begin
               j_d        = '0;
               mem_addr_d = OUTPUT_ADDR;
               state_d    = S_RADDR;
            end
         end
         S_RADDR: state_d = S_RWAIT;
         S_RWAIT: state_d = S_RCAP;
         S_RCAP: begin
            out_data_d  = mem_read_data;
            out_valid_d = 1'b1;
            out_last_d  = (j_q == 3'd7);
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (j_q == 3'd7) begin
                  j_d     = '0;
                  state_d = S_IDLE;
               end else begin
                  j_d        = j_q + 3'd1;
                  mem_addr_d = OUTPUT_ADDR + 16'(j_q + 3'd1);
                  state_d    = S_RADDR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Port ownership follows the next state so mem_sel flips together with it
      mem_sel_d = !((state_d == S_START) || (state_d == S_WAIT));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         i_q              <= '0;
         j_q              <= '0;
         mem_we_q         <= 1'b0;
         mem_sel_q        <= 1'b1;
         mem_addr_q       <= '0;
         mem_write_data_q <= '0;
         out_data_q       <= '0;
         out_valid_q      <= 1'b0;
         out_last_q       <= 1'b0;
         start_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         i_q              <= i_d;
         j_q              <= j_d;
         mem_we_q         <= mem_we_d;
         mem_sel_q        <= mem_sel_d;
         mem_addr_q       <= mem_addr_d;
         mem_write_data_q <= mem_write_data_d;
         out_data_q       <= out_data_d;
         out_valid_q      <= out_valid_d;
         out_last_q       <= out_last_d;
         start_q          <= start_d;
      end
   end

   assign in_ready       = (state_q == S_LOAD);
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_last       = out_last_q;
   assign start          = start_q;
   assign message_addr   = MESSAGE_ADDR;
   assign output_addr    = OUTPUT_ADDR;
   assign mem_sel        = mem_sel_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Bench for sha256_host_ctrl: a 20-word and a 1-word instance share stimulus, each with
// its own memory; a behavioural hasher writes the digest and pulses done.
module tb_sha256_host_ctrl;

   localparam logic [15:0] MSG_BASE = 16'd0;
   localparam logic [15:0] OUT_BASE = 16'd1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, sel;
   logic        in_valid, out_ready, done;
   logic [31:0] in_data;
   logic        h_we;
   logic [15:0] h_addr;
   logic [31:0] h_wdata;

   logic        a_in_ready, a_out_valid, a_out_last, a_start, a_mem_sel, a_mem_we;
   logic [31:0] a_out_data, a_mem_wdata, a_mem_rdata;
   logic [15:0] a_msg_addr, a_out_addr, a_mem_addr, a_pa;
   logic        b_in_ready, b_out_valid, b_out_last, b_start, b_mem_sel, b_mem_we;
   logic [31:0] b_out_data, b_mem_wdata, b_mem_rdata;
   logic [15:0] b_msg_addr, b_out_addr, b_mem_addr, b_pa;

   sha256_host_ctrl #(.NUM_OF_WORDS(20), .MESSAGE_ADDR(MSG_BASE), .OUTPUT_ADDR(OUT_BASE)) dut_a (
      .clk(clk), .reset(rst_a), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last),
      .start(a_start), .message_addr(a_msg_addr), .output_addr(a_out_addr), .done(done),
      .mem_sel(a_mem_sel), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_write_data(a_mem_wdata), .mem_read_data(a_mem_rdata));

   sha256_host_ctrl #(.NUM_OF_WORDS(1), .MESSAGE_ADDR(MSG_BASE), .OUTPUT_ADDR(OUT_BASE)) dut_b (
      .clk(clk), .reset(rst_b), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last),
      .start(b_start), .message_addr(b_msg_addr), .output_addr(b_out_addr), .done(done),
      .mem_sel(b_mem_sel), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_write_data(b_mem_wdata), .mem_read_data(b_mem_rdata));

   // Shared memories with the external port mux: hasher owns the port while mem_sel is low
   logic [31:0] mem_a [0:2047];
   logic [31:0] mem_b [0:2047];
   assign a_pa = a_mem_sel ? a_mem_addr : h_addr;
   assign b_pa = b_mem_sel ? b_mem_addr : h_addr;
   always @(posedge clk) begin
      if (a_mem_sel ? a_mem_we : h_we) mem_a[a_pa[10:0]] <= a_mem_sel ? a_mem_wdata : h_wdata;
      a_mem_rdata <= mem_a[a_pa[10:0]];
   end
   always @(posedge clk) begin
      if (b_mem_sel ? b_mem_we : h_we) mem_b[b_pa[10:0]] <= b_mem_sel ? b_mem_wdata : h_wdata;
      b_mem_rdata <= mem_b[b_pa[10:0]];
   end

   logic        in_ready_m, out_valid_m, out_last_m, start_m, mem_sel_m, mem_we_m, rst_m;
   logic [31:0] out_data_m, mem_wdata_m;
   logic [15:0] mem_addr_m, msg_addr_m, out_addr_m;
   assign in_ready_m  = sel ? b_in_ready  : a_in_ready;
   assign out_valid_m = sel ? b_out_valid : a_out_valid;
   assign out_last_m  = sel ? b_out_last  : a_out_last;
   assign out_data_m  = sel ? b_out_data  : a_out_data;
   assign start_m     = sel ? b_start     : a_start;
   assign mem_sel_m   = sel ? b_mem_sel   : a_mem_sel;
   assign mem_we_m    = sel ? b_mem_we    : a_mem_we;
   assign mem_addr_m  = sel ? b_mem_addr  : a_mem_addr;
   assign mem_wdata_m = sel ? b_mem_wdata : a_mem_wdata;
   assign msg_addr_m  = sel ? b_msg_addr  : a_msg_addr;
   assign out_addr_m  = sel ? b_out_addr  : a_out_addr;
   assign rst_m       = sel ? rst_b       : rst_a;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
   wr_t         wr_q[$];
   int          start_q[$];
   logic [31:0] od_q[$];
   logic        ol_q[$];
   int          oc_q[$];
   int          cyc = 0;
   int          last_acc = -1;
   int          done_cyc = -1;
   logic        prev_stall = 1'b0;
   logic [33:0] prev_out = '0;

   always @(posedge clk) begin
      cyc++;
      if (in_valid && in_ready_m) last_acc = cyc;
      if (start_m) start_q.push_back(cyc);
      if (mem_sel_m && mem_we_m) wr_q.push_back('{mem_addr_m, mem_wdata_m});
      if (done && !mem_sel_m) done_cyc = cyc;
      if (out_valid_m && out_ready) begin
         od_q.push_back(out_data_m);
         ol_q.push_back(out_last_m);
         oc_q.push_back(cyc);
      end
      if (prev_stall) chk("hold_while_stalled", 128'({out_valid_m, out_last_m, out_data_m}), 128'(prev_out));
      prev_stall = out_valid_m && !out_ready && !rst_m;
      prev_out   = {out_valid_m, out_last_m, out_data_m};
   end

   function automatic logic [31:0] rotl1(input logic [31:0] x);
      return {x[30:0], x[31]};
   endfunction

   task automatic reset_dut(input int n);
      @(negedge clk);
      if (sel) rst_b = 1'b1; else rst_a = 1'b1;
      in_valid = 1'b0; done = 1'b0; out_ready = 1'b0; h_we = 1'b0;
      repeat (n) @(negedge clk);
      chk("reset_outputs",
          128'({in_ready_m, out_valid_m, out_last_m, start_m, mem_we_m, mem_sel_m, mem_addr_m, mem_wdata_m, out_data_m}),
          128'({5'b0, 1'b1, 16'd0, 32'd0, 32'd0}));
      chk("const_addrs", 128'({msg_addr_m, out_addr_m}), 128'({MSG_BASE, OUT_BASE}));
      if (sel) rst_b = 1'b0; else rst_a = 1'b0;
      @(negedge clk);
      chk("ready_after_release", 128'(in_ready_m), 128'(1'b1));
   endtask

   typedef struct {
      string       name;
      logic [31:0] w0;
      bit          rnd_words;
      bit          gap;
      bit          done_in_load;
      bit          rnd_ready;
      bit          rnd_digest;
      bit          abort_wait;
      int          exp_start_lat;
      int          exp_rd_cycles;
   } vec_t;

   task automatic run_message(input vec_t v, input int nw);
      logic [31:0] msg [64];
      logic [31:0] dig [8];
      int          i, k, budget, rdy_cnt, cyc_cnt;
      logic        acc;
      msg[0] = v.rnd_words ? $urandom : v.w0;
      for (int w = 1; w < nw; w++) msg[w] = v.rnd_words ? $urandom : rotl1(msg[w-1]);
      for (int n = 0; n < 8; n++) dig[n] = v.rnd_digest ? $urandom : 32'hA000_0000 + 32'(n);
      @(negedge clk);
      wr_q.delete(); start_q.delete(); od_q.delete(); ol_q.delete(); oc_q.delete();
      last_acc = -1; done_cyc = -1;
      budget = 0;
      while (!in_ready_m && budget < 10) begin @(negedge clk); budget++; end
      chk({v.name, ":enter_load"}, 128'(in_ready_m), 128'(1'b1));
      if (!in_ready_m) return;
      i = 0; k = 0; rdy_cnt = 0; cyc_cnt = 0;
      while (i < nw && k < 4 * nw + 8) begin
         cyc_cnt++;
         if (in_ready_m) rdy_cnt++;
         in_valid = !(v.gap && (k % 2 == 1));
         in_data  = msg[i];
         done     = v.done_in_load && (k == 2);
         acc      = in_valid && in_ready_m;
         @(negedge clk);
         if (acc) i++;
         k++;
      end
      in_valid = 1'b0; done = 1'b0;
      chk({v.name, ":in_ready_during_load"}, 128'(rdy_cnt), 128'(cyc_cnt));
      budget = 0;
      while (start_q.size() == 0 && budget < 10) begin @(negedge clk); budget++; end
      repeat (3) @(negedge clk);
      chk({v.name, ":start_pulses"}, 128'(start_q.size()), 128'(1));
      if (start_q.size() > 0) chk({v.name, ":start_latency"}, 128'(start_q[0] - last_acc), 128'(v.exp_start_lat));
      chk({v.name, ":write_count"}, 128'(wr_q.size()), 128'(nw));
      for (int w = 0; w < nw && w < wr_q.size(); w++)
         chk({v.name, ":write"}, 128'({wr_q[w].a, wr_q[w].d}), 128'({MSG_BASE + 16'(w), msg[w]}));
      chk({v.name, ":mem_sel_in_wait"}, 128'(mem_sel_m), 128'(1'b0));
      if (v.abort_wait) begin
         reset_dut(2);
         return;
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      for (int n = 0; n < 8; n++) begin
         h_we = 1'b1; h_addr = OUT_BASE + 16'(n); h_wdata = dig[n];
         @(negedge clk);
      end
      h_we = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      budget = 0;
      while (od_q.size() < 8 && budget < 400) begin
         out_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         budget++;
      end
      out_ready = 1'b0;
      chk({v.name, ":digest_count"}, 128'(od_q.size()), 128'(8));
      chk({v.name, ":valid_after_last"}, 128'(out_valid_m), 128'(1'b0));
      for (int n = 0; n < 8 && n < od_q.size(); n++) begin
         chk({v.name, ":digest_word"}, 128'(od_q[n]), 128'(dig[n]));
         chk({v.name, ":digest_last"}, 128'(ol_q[n]), 128'(n == 7));
      end
      if (v.exp_rd_cycles > 0 && oc_q.size() == 8) begin
         chk({v.name, ":first_word_latency"}, 128'(oc_q[0] - done_cyc), 128'(4));
         chk({v.name, ":read_cycles"}, 128'(oc_q[7] - done_cyc), 128'(v.exp_rd_cycles));
      end
   endtask

   vec_t vt [6];
   vec_t vb;

   initial begin
      sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; done = 1'b0;
      h_we = 1'b0; h_addr = '0; h_wdata = '0;
      //        name             w0            rndw  gap   dinl  rrdy  rdig  abort lat rd
      vt[0] = '{"rot_stream",    32'h01234675, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 32};
      vt[1] = '{"rot_gapped",    32'h01234675, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, -1};
      vt[2] = '{"done_in_load",  32'h0,        1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, 1'b0, 2, -1};
      vt[3] = '{"abort_in_wait", 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, -1};
      vt[4] = '{"after_abort",   32'h0,        1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1, 1'b0, 2, -1};
      vt[5] = '{"rand_msg",      32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 32};
      vb    = '{"one_word",      32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 32};

      reset_dut(3);
      for (int v = 0; v < 6; v++) run_message(vt[v], 20);

      @(negedge clk);
      rst_a = 1'b1;
      sel = 1'b1;
      reset_dut(3);
      run_message(vb, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
